// File: rtl/bbox_pkg.sv
// Shared types and constants for the ping-pong bounding-box accumulator.
// BBOX_PIXCNT_EN adds a per-entry pixel count field to bbox_entry_t.
package bbox_pkg;

    localparam int unsigned DEF_X_BITS   = 11;
    localparam int unsigned DEF_Y_BITS   = 10;
    localparam int unsigned DEF_CNT_BITS = DEF_X_BITS + DEF_Y_BITS;

    // Seed values that make the first merge into an empty entry load the beat itself.
    localparam logic [31:0] CLR_MIN = 32'hFFFF_FFFF;
    localparam logic [31:0] CLR_MAX = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_X_BITS-1:0]   min_x;
        logic [DEF_X_BITS-1:0]   max_x;
        logic [DEF_Y_BITS-1:0]   min_y;
        logic [DEF_Y_BITS-1:0]   max_y;
`ifdef BBOX_PIXCNT_EN
        logic [DEF_CNT_BITS-1:0] cnt;
`endif
    } bbox_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StHold,
        StDone
    } drain_state_t;

endpackage

// File: rtl/bbox_accum_pp_bank.sv
// One box bank: per-label active bit plus min/max (and optional pixel count) storage.
// Single-cycle read-modify-write accumulate port, read/clear port, bulk clear. BBOX_PIXCNT_EN.
module bbox_bank
    import bbox_pkg::*;
#(
    parameter int unsigned NUM_LABELS = 256,
    parameter int unsigned IDX_BITS   = 8,
    parameter int unsigned X_BITS     = DEF_X_BITS,
    parameter int unsigned Y_BITS     = DEF_Y_BITS,
`ifdef BBOX_PIXCNT_EN
    parameter int unsigned CNT_BITS   = DEF_CNT_BITS,
`endif
    parameter type entry_t = bbox_entry_t
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                acc_en,
    input  logic [IDX_BITS-1:0] acc_idx,
    input  logic [X_BITS-1:0]   acc_x,
    input  logic [Y_BITS-1:0]   acc_y,
    input  logic [IDX_BITS-1:0] rd_idx,
    input  logic                rd_clr,
    input  logic                bulk_clr,
    output logic                rd_active,
    output entry_t              rd_entry
);

    logic [NUM_LABELS-1:0] active_q, active_d;
    entry_t                entry_q [NUM_LABELS];
    entry_t                base, nxt;

    always_comb begin
        base = entry_q[acc_idx];
        if (!active_q[acc_idx]) begin
            base.min_x = CLR_MIN[X_BITS-1:0];
            base.max_x = CLR_MAX[X_BITS-1:0];
            base.min_y = CLR_MIN[Y_BITS-1:0];
            base.max_y = CLR_MAX[Y_BITS-1:0];
`ifdef BBOX_PIXCNT_EN
            base.cnt   = '0;
`endif
        end
        nxt = base;
        if (acc_x < base.min_x) nxt.min_x = acc_x;
        if (acc_x > base.max_x) nxt.max_x = acc_x;
        if (acc_y < base.min_y) nxt.min_y = acc_y;
        if (acc_y > base.max_y) nxt.max_y = acc_y;
`ifdef BBOX_PIXCNT_EN
        if (!(&base.cnt)) nxt.cnt = base.cnt + CNT_BITS'(1);
`endif
    end

    // Bulk clear drops a whole overrun frame, including a beat landing in the same cycle.
    always_comb begin
        active_d = active_q;
        if (acc_en) active_d[acc_idx] = 1'b1;
        if (rd_clr) active_d[rd_idx] = 1'b0;
        if (bulk_clr) active_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
        end else begin
            active_q <= active_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_en) entry_q[acc_idx] <= nxt;
    end

    assign rd_active = active_q[rd_idx];
    assign rd_entry  = entry_q[rd_idx];

endmodule

// File: rtl/bbox_accum_pp.sv
// Ping-pong per-label bounding-box accumulator; drains the completed bank over valid/ready.
// Optional BBOX_PIXCNT_EN: per-entry pixel counts with a min_pixels emission threshold.
module bbox_accum_pp
    import bbox_pkg::*;
#(
    parameter int unsigned WIDTH_BITS  = 11,
    parameter int unsigned HEIGHT_BITS = 10,
    parameter int unsigned LABEL_WIDTH = 8,
    parameter int unsigned NUM_LABELS  = 1 << LABEL_WIDTH,
    parameter int unsigned CNT_BITS    = WIDTH_BITS + HEIGHT_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   pix_valid,
    input  logic [LABEL_WIDTH-1:0] pix_label,
    input  logic [WIDTH_BITS-1:0]  pix_x,
    input  logic [HEIGHT_BITS-1:0] pix_y,
    input  logic                   frame_end,
`ifdef BBOX_PIXCNT_EN
    input  logic [CNT_BITS-1:0]    min_pixels,
    output logic [CNT_BITS-1:0]    box_pixels,
`endif
    output logic                   box_valid,
    input  logic                   box_ready,
    output logic [LABEL_WIDTH-1:0] box_label,
    output logic [WIDTH_BITS-1:0]  box_min_x,
    output logic [WIDTH_BITS-1:0]  box_max_x,
    output logic [HEIGHT_BITS-1:0] box_min_y,
    output logic [HEIGHT_BITS-1:0] box_max_y,
    output logic                   frame_done,
    output logic [LABEL_WIDTH:0]   frame_boxes,
    output logic [7:0]             overrun_cnt,
    output logic                   label_err
);

    localparam int unsigned IDX_BITS = $clog2(NUM_LABELS);
    localparam logic [LABEL_WIDTH-1:0] LAST_IDX  = LABEL_WIDTH'(NUM_LABELS - 1);
    localparam logic [LABEL_WIDTH:0]   NUM_LBL_W = (LABEL_WIDTH + 1)'(NUM_LABELS);

    if (NUM_LABELS < 2 || NUM_LABELS > (1 << LABEL_WIDTH) || CNT_BITS < 1) begin : g_bad_cfg
        $error("bbox_accum_pp: unsupported parameter set");
    end

    typedef struct packed {
        logic [WIDTH_BITS-1:0]  min_x;
        logic [WIDTH_BITS-1:0]  max_x;
        logic [HEIGHT_BITS-1:0] min_y;
        logic [HEIGHT_BITS-1:0] max_y;
`ifdef BBOX_PIXCNT_EN
        logic [CNT_BITS-1:0]    cnt;
`endif
    } entry_t;

    drain_state_t           state_q, state_d;
    logic                   acc_sel_q;
    logic [LABEL_WIDTH-1:0] idx_q, idx_d;
    logic [LABEL_WIDTH:0]   count_q, count_d;
    logic                   in_range, acc_ok, overrun, start, last;
    logic                   drain_clr, load, pass, frame_done_d, box_valid_d;
    logic [1:0]             bank_active;
    entry_t                 bank_entry [2];
    entry_t                 drain_entry;
    logic                   drain_active;

    assign in_range = {1'b0, pix_label} < NUM_LBL_W;
    assign acc_ok   = enable && pix_valid && in_range && (pix_label != '0);
    assign start    = enable && frame_end && (state_q == StIdle);
    assign overrun  = enable && frame_end && (state_q != StIdle);
    assign last     = (idx_q == LAST_IDX);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        bbox_bank #(
            .NUM_LABELS (NUM_LABELS),
            .IDX_BITS   (IDX_BITS),
            .X_BITS     (WIDTH_BITS),
            .Y_BITS     (HEIGHT_BITS),
`ifdef BBOX_PIXCNT_EN
            .CNT_BITS   (CNT_BITS),
`endif
            .entry_t    (entry_t)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .acc_en    (acc_ok && (acc_sel_q == 1'(b))),
            .acc_idx   (pix_label[IDX_BITS-1:0]),
            .acc_x     (pix_x),
            .acc_y     (pix_y),
            .rd_idx    (idx_q[IDX_BITS-1:0]),
            .rd_clr    (drain_clr && (acc_sel_q != 1'(b))),
            .bulk_clr  (overrun && (acc_sel_q == 1'(b))),
            .rd_active (bank_active[b]),
            .rd_entry  (bank_entry[b])
        );
    end

    // The drained bank is always the one not currently accumulating.
    assign drain_active = acc_sel_q ? bank_active[0] : bank_active[1];
    assign drain_entry  = acc_sel_q ? bank_entry[0] : bank_entry[1];

`ifdef BBOX_PIXCNT_EN
    assign pass = (drain_entry.cnt >= min_pixels);
`else
    assign pass = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        count_d      = count_q;
        drain_clr    = 1'b0;
        load         = 1'b0;
        frame_done_d = 1'b0;
        box_valid_d  = box_valid;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                    idx_d   = LABEL_WIDTH'(1);
                    count_d = '0;
                end
            end
            StScan: begin
                if (enable) begin
                    if (drain_active) begin
                        drain_clr = 1'b1;
                        if (pass) begin
                            load        = 1'b1;
                            box_valid_d = 1'b1;
                            count_d     = count_q + (LABEL_WIDTH + 1)'(1);
                            state_d     = StHold;
                        end
                    end
                    if (state_d == StScan) begin
                        if (last) begin
                            state_d      = StDone;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + LABEL_WIDTH'(1);
                        end
                    end
                end
            end
            StHold: begin
                if (enable && box_ready) begin
                    box_valid_d = 1'b0;
                    if (last) begin
                        state_d      = StDone;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = StScan;
                        idx_d   = idx_q + LABEL_WIDTH'(1);
                    end
                end
            end
            StDone: begin
                if (enable) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_sel_q   <= 1'b0;
            idx_q       <= '0;
            count_q     <= '0;
            box_valid   <= 1'b0;
            box_label   <= '0;
            box_min_x   <= '0;
            box_max_x   <= '0;
            box_min_y   <= '0;
            box_max_y   <= '0;
`ifdef BBOX_PIXCNT_EN
            box_pixels  <= '0;
`endif
            frame_done  <= 1'b0;
            frame_boxes <= '0;
            overrun_cnt <= '0;
            label_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            box_valid  <= box_valid_d;
            frame_done <= frame_done_d;
            if (start) acc_sel_q <= ~acc_sel_q;
            if (frame_done_d) frame_boxes <= count_q;
            if (overrun && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
            if (enable && pix_valid && !in_range) label_err <= 1'b1;
            if (load) begin
                box_label  <= idx_q;
                box_min_x  <= drain_entry.min_x;
                box_max_x  <= drain_entry.max_x;
                box_min_y  <= drain_entry.min_y;
                box_max_y  <= drain_entry.max_y;
`ifdef BBOX_PIXCNT_EN
                box_pixels <= drain_entry.cnt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bbox_accum_pp.sv
// Directed scoreboard bench for bbox_accum_pp with NUM_LABELS=16.
// The min_pixels scenario runs only when BBOX_PIXCNT_EN is defined.
module tb_bbox_accum_pp;

    localparam int XW = 11;
    localparam int YW = 10;
    localparam int LW = 8;
    localparam int NL = 16;
    localparam int CW = XW + YW;

    logic          clk = 1'b0;
    logic          rst_n, enable, pix_valid, frame_end, box_ready;
    logic [LW-1:0] pix_label, box_label;
    logic [XW-1:0] pix_x, box_min_x, box_max_x;
    logic [YW-1:0] pix_y, box_min_y, box_max_y;
    logic          box_valid, frame_done, label_err;
    logic [LW:0]   frame_boxes;
    logic [7:0]    overrun_cnt;
`ifdef BBOX_PIXCNT_EN
    logic [CW-1:0] min_pixels, box_pixels;
`endif

    always #5 clk = ~clk;

    bbox_accum_pp #(
        .WIDTH_BITS  (XW),
        .HEIGHT_BITS (YW),
        .LABEL_WIDTH (LW),
        .NUM_LABELS  (NL),
        .CNT_BITS    (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pix_valid   (pix_valid),
        .pix_label   (pix_label),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_end   (frame_end),
`ifdef BBOX_PIXCNT_EN
        .min_pixels  (min_pixels),
        .box_pixels  (box_pixels),
`endif
        .box_valid   (box_valid),
        .box_ready   (box_ready),
        .box_label   (box_label),
        .box_min_x   (box_min_x),
        .box_max_x   (box_max_x),
        .box_min_y   (box_min_y),
        .box_max_y   (box_max_y),
        .frame_done  (frame_done),
        .frame_boxes (frame_boxes),
        .overrun_cnt (overrun_cnt),
        .label_err   (label_err)
    );

    typedef struct {
        logic [LW-1:0] label;
        logic [XW-1:0] min_x;
        logic [XW-1:0] max_x;
        logic [YW-1:0] min_y;
        logic [YW-1:0] max_y;
        logic [CW-1:0] pix;
    } rec_t;

    rec_t        exp_q[$];
    logic [LW:0] frm_q[$];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_rec(input int l, input int mnx, input int mxx, input int mny,
                            input int mxy, input int pix);
        rec_t r;
        r.label = LW'(l);
        r.min_x = XW'(mnx);
        r.max_x = XW'(mxx);
        r.min_y = YW'(mny);
        r.max_y = YW'(mxy);
        r.pix   = CW'(pix);
        exp_q.push_back(r);
    endtask

    task automatic beat(input int l, input int x, input int y, input bit fe);
        pix_valid = 1'b1;
        pix_label = LW'(l);
        pix_x     = XW'(x);
        pix_y     = YW'(y);
        frame_end = fe;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_wait(input string tag);
        for (int i = 0; i < 2000 && frm_q.size() != 0; i++) @(negedge clk);
        check(tag, 64'(frm_q.size()), 64'd0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 50 && !box_valid; i++) @(negedge clk);
        check(tag, 64'(box_valid), 64'd1);
    endtask

    // Record and frame monitor: every valid cycle is compared against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (box_valid) begin
                check("record_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check("record", 64'({box_label, box_min_x, box_max_x, box_min_y, box_max_y}),
                          64'({exp_q[0].label, exp_q[0].min_x, exp_q[0].max_x,
                               exp_q[0].min_y, exp_q[0].max_y}));
`ifdef BBOX_PIXCNT_EN
                    check("box_pixels", 64'(box_pixels), 64'(exp_q[0].pix));
`endif
                    if (box_ready && enable) void'(exp_q.pop_front());
                end
            end
            if (frame_done) begin
                check("frame_expected", 64'(frm_q.size() != 0), 64'd1);
                if (frm_q.size() != 0) check("frame_boxes", 64'(frame_boxes), 64'(frm_q.pop_front()));
            end
        end
    end

    initial begin
        int lat;
        rst_n     = 1'b0;
        enable    = 1'b1;
        pix_valid = 1'b0;
        pix_label = '0;
        pix_x     = '0;
        pix_y     = '0;
        frame_end = 1'b0;
        box_ready = 1'b1;
`ifdef BBOX_PIXCNT_EN
        min_pixels = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_outputs", 64'({box_valid, frame_done, frame_boxes, overrun_cnt, label_err}), 64'd0);
        sync();
        rst_n = 1'b1;
        sync();

        // Single label, consecutive beats on the same label.
        push_rec(3, 1, 9, 2, 7, 3);
        frm_q.push_back(9'd1);
        beat(3, 5, 2, 1'b0);
        beat(3, 9, 7, 1'b0);
        beat(3, 1, 4, 1'b1);
        drain_wait("t1_drain");

        // Four labels, stalled 10 cycles, ascending emission.
        box_ready = 1'b0;
        push_rec(1, 0, 0, 0, 0, 1);
        push_rec(2, 3, 7, 8, 9, 2);
        push_rec(3, 2000, 2047, 1000, 1023, 2);
        push_rec(4, 100, 100, 50, 50, 1);
        frm_q.push_back(9'd4);
        sync();
        beat(4, 100, 50, 1'b0);
        beat(2, 7, 8, 1'b0);
        beat(2, 3, 9, 1'b0);
        beat(1, 0, 0, 1'b0);
        beat(3, 2047, 1023, 1'b0);
        beat(3, 2000, 1000, 1'b1);
        repeat (10) @(negedge clk);
        check("t2_stall_valid", 64'(box_valid), 64'd1);
        check("t2_stall_label", 64'(box_label), 64'd1);
        box_ready = 1'b1;
        drain_wait("t2_drain");

        // Overrun while the first drain is stalled.
        box_ready = 1'b0;
        push_rec(5, 10, 20, 10, 30, 2);
        push_rec(7, 3, 3, 3, 3, 1);
        frm_q.push_back(9'd2);
        sync();
        beat(5, 10, 10, 1'b0);
        beat(5, 20, 30, 1'b0);
        beat(7, 3, 3, 1'b1);
        wait_valid("t3_first_valid");
        sync();
        beat(6, 1, 1, 1'b1);
        repeat (2) @(negedge clk);
        check("t3_overrun", 64'(overrun_cnt), 64'd1);
        box_ready = 1'b1;
        drain_wait("t3_drain");

        // Background and out-of-range labels; empty-frame latency.
        check("t4_label_err_before", 64'(label_err), 64'd0);
        frm_q.push_back(9'd0);
        sync();
        beat(0, 3, 3, 1'b0);
        beat(NL, 4, 4, 1'b1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (frame_done) begin
                lat = i;
                break;
            end
        end
        check("t4_latency", 64'(lat), 64'(NL));
        check("t4_label_err", 64'(label_err), 64'd1);
        drain_wait("t4_drain");

`ifdef BBOX_PIXCNT_EN
        // Threshold filter: label 2 has two pixels, label 5 has three.
        min_pixels = CW'(3);
        push_rec(5, 4, 6, 4, 6, 3);
        frm_q.push_back(9'd1);
        sync();
        beat(2, 1, 1, 1'b0);
        beat(2, 2, 2, 1'b0);
        beat(5, 4, 4, 1'b0);
        beat(5, 5, 5, 1'b0);
        beat(5, 6, 6, 1'b1);
        drain_wait("t5_drain");
        min_pixels = '0;
`endif

        // Reset while holding a record.
        box_ready = 1'b0;
        push_rec(2, 1, 1, 1, 1, 1);
        frm_q.push_back(9'd1);
        sync();
        beat(2, 1, 1, 1'b1);
        wait_valid("t6_hold");
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(box_valid), 64'd0);
        check("t6_rst_flags", 64'({overrun_cnt, label_err, frame_done}), 64'd0);
        exp_q.delete();
        frm_q.delete();
        sync();
        rst_n     = 1'b1;
        box_ready = 1'b1;
        push_rec(9, 2, 2, 3, 3, 1);
        frm_q.push_back(9'd1);
        sync();
        beat(9, 2, 3, 1'b1);
        drain_wait("t6_drain");
        check("final_records_left", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
